// File: rtl/calc_pkg.sv
// Shared types for the calculator datapath: ALU opcodes and FSM states.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } op_t;

  // Encodings are exported on state_o for the display mux, so keep them fixed.
  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_DONE    = 3'd3
  } state_t;

endpackage

// File: rtl/calc_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, LSB first.
// o_done is asserted combinationally during the final step so the caller can
// register o_product on the same edge that retires the last partial product.
module calc_mul_seq #(
  parameter int IN_W  = 4,
  parameter int RES_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_clear,
  input  logic                  i_start,
  input  logic [RES_W-1:0]      i_a,
  input  logic [IN_W-1:0]       i_b,
  output logic                  o_done,
  output logic [RES_W+IN_W-1:0] o_product
);

  localparam int PW = RES_W + IN_W;
  localparam logic [IN_W-1:0] LAST = IN_W[IN_W-1:0] - 1'b1;

  logic [PW-1:0]   r_acc, r_mcand;
  logic [IN_W-1:0] r_mplr, r_cnt;
  logic            r_run;
  logic [PW-1:0]   w_addend, w_sum;

  assign w_addend  = r_mplr[0] ? r_mcand : '0;
  assign w_sum     = r_acc + w_addend;
  assign o_done    = r_run && (r_cnt == LAST);
  assign o_product = w_sum;

  // Load operands on start, then accumulate one shifted multiplicand per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
    end else if (i_clear) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
    end else if (i_start) begin
      r_acc   <= '0;
      r_mcand <= {{IN_W{1'b0}}, i_a};
      r_mplr  <= i_b;
      r_cnt   <= '0;
      r_run   <= 1'b1;
    end else if (r_run) begin
      r_acc   <= w_sum;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + 1'b1;
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_core.sv
// Calculator datapath: operand entry FSM, registered ALU and status flags.
// MUL is delegated to calc_mul_seq; the other ops complete in one EXEC cycle.
module calc_core
  import calc_pkg::*;
#(
  parameter int IN_W  = 4,
  parameter int RES_W = 8,
  parameter int CHAIN = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             progress,
  input  logic [1:0]       op,
  input  logic [IN_W-1:0]  switch_in,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  output logic             negative,
  output logic             overflow,
  output logic             busy,
  output logic [2:0]       state_o
);

  state_t           r_state, w_next;
  op_t              r_op;
  logic [RES_W-1:0] r_a, r_result;
  logic [IN_W-1:0]  r_b;
  logic             r_neg, r_ovf;

  logic                  w_mul_start, w_mul_done, w_exec_done;
  logic [RES_W+IN_W-1:0] w_mul_prod;
  logic [RES_W-1:0]      w_b_ext, w_alu_res;
  logic [RES_W:0]        w_add;
  logic                  w_alu_neg, w_alu_ovf;

  assign w_b_ext     = {{(RES_W-IN_W){1'b0}}, r_b};
  assign w_add       = {1'b0, r_a} + {1'b0, w_b_ext};
  assign w_mul_start = (r_state == ST_ENTER_B) && progress && !clear &&
                       (op_t'(op) == OP_MUL);
  assign w_exec_done = (r_state == ST_EXEC) && ((r_op != OP_MUL) || w_mul_done);

  calc_mul_seq #(.IN_W(IN_W), .RES_W(RES_W)) u_mul (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (clear),
    .i_start   (w_mul_start),
    .i_a       (r_a),
    .i_b       (switch_in),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );

  // ALU result and flags for the latched op, consumed on the EXEC->DONE edge.
  always_comb begin
    w_alu_res = '0;
    w_alu_neg = 1'b0;
    w_alu_ovf = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_alu_res = w_add[RES_W-1:0];
        w_alu_ovf = w_add[RES_W];
      end
      OP_SUB: begin
        w_alu_res = r_a - w_b_ext;
        w_alu_neg = (r_a < w_b_ext);
      end
      OP_MUL: begin
        w_alu_res = w_mul_prod[RES_W-1:0];
        w_alu_ovf = |w_mul_prod[RES_W+IN_W-1:RES_W];
      end
      default: w_alu_res = r_a & w_b_ext;
    endcase
  end

  // Next-state logic; clear overrides any simultaneous progress.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ENTER_A: if (progress) w_next = ST_ENTER_B;
      ST_ENTER_B: if (progress) w_next = ST_EXEC;
      ST_EXEC:    if (w_exec_done) w_next = ST_DONE;
      ST_DONE:    if (progress) w_next = (CHAIN != 0) ? ST_ENTER_B : ST_ENTER_A;
      default:    w_next = ST_ENTER_A;
    endcase
    if (clear) w_next = ST_ENTER_A;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_ENTER_A;
    else          r_state <= w_next;
  end

  // Operand latches and registered result/flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (clear) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if ((r_state == ST_ENTER_A) && progress)
        r_a <= {{(RES_W-IN_W){1'b0}}, switch_in};
      if ((r_state == ST_ENTER_B) && progress) begin
        r_b  <= switch_in;
        r_op <= op_t'(op);
      end
      if (w_exec_done) begin
        r_result <= w_alu_res;
        r_neg    <= w_alu_neg;
        r_ovf    <= w_alu_ovf;
      end
      if ((r_state == ST_DONE) && progress && (CHAIN != 0))
        r_a <= r_result;
    end
  end

  assign result       = r_result;
  assign negative     = r_neg;
  assign overflow     = r_ovf;
  assign busy         = (r_state == ST_EXEC);
  assign result_valid = (r_state == ST_DONE);
  assign state_o      = r_state;

endmodule

// File: tb/tb_calc_core.sv
// Directed bench for calc_core: a vector table for single operations plus
// hand-written sequences for chaining, clear/progress races and async reset.
module tb_calc_core;

  logic       clk = 1'b0;
  logic       reset_n, clear, progress;
  logic [1:0] op;
  logic [3:0] switch_in;
  logic [7:0] result, result0;
  logic       result_valid, negative, overflow, busy;
  logic       result_valid0, negative0, overflow0, busy0;
  logic [2:0] state_o, state_o0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  calc_core #(.IN_W(4), .RES_W(8), .CHAIN(1)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .progress(progress),
    .op(op), .switch_in(switch_in), .result(result),
    .result_valid(result_valid), .negative(negative), .overflow(overflow),
    .busy(busy), .state_o(state_o)
  );

  // Non-chaining instance on the same stimulus, checked only where CHAIN matters.
  calc_core #(.IN_W(4), .RES_W(8), .CHAIN(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .progress(progress),
    .op(op), .switch_in(switch_in), .result(result0),
    .result_valid(result_valid0), .negative(negative0), .overflow(overflow0),
    .busy(busy0), .state_o(state_o0)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [7:0] res;
    logic       neg;
    logic       ovf;
    int         bcyc;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic pulse(input logic [3:0] sw, input logic [1:0] o);
    @(negedge clk);
    switch_in = sw;
    op        = o;
    progress  = 1'b1;
    @(negedge clk);
    progress  = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  // Enter B/op, then count busy cycles until DONE (bounded).
  task automatic run_b(input logic [3:0] b, input logic [1:0] o, output int n);
    pulse(b, o);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    vt[0] = '{4'd9,  4'd5,  2'b00, 8'h0E, 1'b0, 1'b0, 1};
    vt[1] = '{4'd3,  4'd7,  2'b01, 8'hFC, 1'b1, 1'b0, 1};
    vt[2] = '{4'd15, 4'd15, 2'b10, 8'hE1, 1'b0, 1'b0, 4};
    vt[3] = '{4'hC,  4'hA,  2'b11, 8'h08, 1'b0, 1'b0, 1};
    vt[4] = '{4'd15, 4'd15, 2'b00, 8'h1E, 1'b0, 1'b0, 1};
    vt[5] = '{4'd15, 4'd1,  2'b01, 8'h0E, 1'b0, 1'b0, 1};
    vt[6] = '{4'd0,  4'd5,  2'b10, 8'h00, 1'b0, 1'b0, 4};
    vt[7] = '{4'd6,  4'd7,  2'b10, 8'h2A, 1'b0, 1'b0, 4};

    reset_n = 1'b0; clear = 1'b0; progress = 1'b0; op = 2'b00; switch_in = 4'd0;
    #3;
    chk("rst_result", 32'(result), 32'h0);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_valid_busy", {30'd0, result_valid, busy}, 32'd0);
    chk("rst_flags", {30'd0, negative, overflow}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table: one complete operation per vector.
    for (int i = 0; i < 8; i++) begin
      do_clear();
      pulse(vt[i].a, 2'b00);
      run_b(vt[i].b, vt[i].op, n);
      chk($sformatf("v%0d_busy", i), 32'(n), 32'(vt[i].bcyc));
      chk($sformatf("v%0d_valid", i), {31'd0, result_valid}, 32'd1);
      chk($sformatf("v%0d_result", i), 32'(result), 32'(vt[i].res));
      chk($sformatf("v%0d_neg", i), {31'd0, negative}, {31'd0, vt[i].neg});
      chk($sformatf("v%0d_ovf", i), {31'd0, overflow}, {31'd0, vt[i].ovf});
    end

    // SUB with progress held through the EXEC cycle: the extra pulse is dropped.
    do_clear();
    pulse(4'd3, 2'b00);
    @(negedge clk); switch_in = 4'd7; op = 2'b01; progress = 1'b1;
    @(negedge clk); chk("sub_exec_busy", {31'd0, busy}, 32'd1);
    switch_in = 4'd1; op = 2'b00;
    @(negedge clk); progress = 1'b0;
    chk("sub_hold_state", 32'(state_o), 32'd3);
    chk("sub_hold_result", 32'(result), 32'hFC);
    chk("sub_hold_neg", {31'd0, negative}, 32'd1);
    @(negedge clk);
    chk("sub_still_done", 32'(state_o), 32'd3);

    // MUL with a progress pulse mid-EXEC: still 4 busy cycles, result intact.
    do_clear();
    pulse(4'd3, 2'b00);
    pulse(4'd7, 2'b10);
    n = 1;
    @(negedge clk); n++; progress = 1'b1;
    @(negedge clk); n++; progress = 1'b0;
    while (busy && n < 50) begin
      @(negedge clk);
      if (busy) n++;
    end
    chk("mulp_busy", 32'(n), 32'd4);
    chk("mulp_result", 32'(result), 32'h15);
    @(negedge clk);
    chk("mulp_still_done", 32'(state_o), 32'd3);

    // Chaining: 15*15=225, +2=0xE3, *15=0xD4D, -15=0x3E (clears overflow).
    do_clear();
    pulse(4'd15, 2'b00);
    run_b(4'd15, 2'b10, n);
    chk("ch_mul1", 32'(result), 32'hE1);
    pulse(4'd0, 2'b00);
    chk("ch_state_b", 32'(state_o), 32'd1);
    chk("ch0_state_a", 32'(state_o0), 32'd0);
    run_b(4'd2, 2'b00, n);
    chk("ch_add", 32'(result), 32'hE3);
    chk("ch_add_ovf", {31'd0, overflow}, 32'd0);
    pulse(4'd0, 2'b00);
    run_b(4'd15, 2'b10, n);
    chk("ch_mul2_busy", 32'(n), 32'd4);
    chk("ch_mul2", 32'(result), 32'h4D);
    chk("ch_mul2_ovf", {31'd0, overflow}, 32'd1);
    pulse(4'd0, 2'b00);
    run_b(4'd15, 2'b01, n);
    chk("ch_sub", 32'(result), 32'h3E);
    chk("ch_sub_flags", {30'd0, negative, overflow}, 32'd0);

    // ADD carry-out through chaining: 225+15=240, +15=255, +1=256 -> 0x00 ovf.
    do_clear();
    pulse(4'd15, 2'b00);
    run_b(4'd15, 2'b10, n);
    pulse(4'd0, 2'b00); run_b(4'd15, 2'b00, n);
    pulse(4'd0, 2'b00); run_b(4'd15, 2'b00, n);
    chk("ch_255", 32'(result), 32'hFF);
    pulse(4'd0, 2'b00); run_b(4'd1, 2'b00, n);
    chk("ch_wrap_result", 32'(result), 32'h00);
    chk("ch_wrap_ovf", {31'd0, overflow}, 32'd1);

    // CHAIN=0 instance returns to ENTER_A after DONE.
    do_clear();
    pulse(4'hC, 2'b00);
    run_b(4'hA, 2'b11, n);
    chk("and_result0", 32'(result0), 32'h08);
    pulse(4'd0, 2'b00);
    chk("nochain_state", 32'(state_o0), 32'd0);
    chk("chain_state", 32'(state_o), 32'd1);

    // Clear and progress together in ENTER_B: clear wins, regs zeroed.
    do_clear();
    pulse(4'd3, 2'b00);
    run_b(4'd7, 2'b01, n);
    pulse(4'd0, 2'b00);
    chk("cp_pre_state", 32'(state_o), 32'd1);
    @(negedge clk); clear = 1'b1; progress = 1'b1; switch_in = 4'd5;
    @(negedge clk); clear = 1'b0; progress = 1'b0;
    chk("cp_state", 32'(state_o), 32'd0);
    chk("cp_result", 32'(result), 32'h0);
    chk("cp_neg", {31'd0, negative}, 32'd0);
    // A was zeroed: 0 + 4 = 4.
    pulse(4'd0, 2'b00);
    run_b(4'd4, 2'b00, n);
    chk("cp_after", 32'(result), 32'h04);

    // Async reset in the middle of a MUL.
    do_clear();
    pulse(4'd3, 2'b00);
    run_b(4'd7, 2'b00, n);
    pulse(4'd0, 2'b00);
    pulse(4'd15, 2'b10);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("ar_result", 32'(result), 32'h0);
    chk("ar_state", 32'(state_o), 32'd0);
    chk("ar_valid_busy", {30'd0, result_valid, busy}, 32'd0);
    chk("ar_flags", {30'd0, negative, overflow}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pulse(4'd2, 2'b00);
    run_b(4'd3, 2'b10, n);
    chk("ar_recover_busy", 32'(n), 32'd4);
    chk("ar_recover", 32'(result), 32'h06);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
